// File: rtl/fir_cmplx_decim.sv
// Complex-coefficient decimating FIR, one complex MAC per tap per cycle.
// Latency: last input pop -> output write is NUM_TAPS+2 cycles when the output FIFOs have room.
// Backpressure: either output FIFO full holds the result in S_OUT, with no write and no input pops.
//
// Ports:
//   clock, reset                     rising-edge clock, asynchronous active-high reset
//   xreal_in_*, ximag_in_*           paired first-word-fall-through input FIFOs (dout/empty/rd_en)
//   yreal_out_*, yimag_out_*         paired output FIFOs (din/full/wr_en)
module fir_cmplx_decim #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 10,
  parameter int NUM_TAPS   = 20,
  parameter int DECIMATION = 1,
  parameter logic [0:NUM_TAPS-1][DATA_WIDTH-1:0] COEFF_REAL = '0,
  parameter logic [0:NUM_TAPS-1][DATA_WIDTH-1:0] COEFF_IMAG = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] xreal_in_dout,
  input  logic                  xreal_in_empty,
  output logic                  xreal_in_rd_en,
  input  logic [DATA_WIDTH-1:0] ximag_in_dout,
  input  logic                  ximag_in_empty,
  output logic                  ximag_in_rd_en,
  output logic [DATA_WIDTH-1:0] yreal_out_din,
  input  logic                  yreal_out_full,
  output logic                  yreal_out_wr_en,
  output logic [DATA_WIDTH-1:0] yimag_out_din,
  input  logic                  yimag_out_full,
  output logic                  yimag_out_wr_en
);

  localparam int PW    = 2 * DATA_WIDTH;
  // One extra count value so the drain cycle index never aliases tap 0.
  localparam int TAP_W = $clog2(NUM_TAPS + 1);
  localparam int DEC_W = $clog2(DECIMATION + 1);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS);
  localparam logic [DEC_W-1:0] LAST_POP = DEC_W'(DECIMATION - 1);

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_OUT} state_t;

  state_t state_q, state_d;
  logic signed [DATA_WIDTH-1:0] sr_r_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] sr_r_d [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] sr_i_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0] sr_i_d [NUM_TAPS];
  logic [DEC_W-1:0] pop_cnt_q, pop_cnt_d;
  logic [TAP_W-1:0] tap_cnt_q, tap_cnt_d;
  logic signed [PW-1:0] pr_q, pr_d, pi_q, pi_d, pri_q, pri_d, pir_q, pir_d;
  logic signed [DATA_WIDTH-1:0] acc_r_q, acc_r_d, acc_i_q, acc_i_d;

  logic pop, push;
  logic signed [DATA_WIDTH-1:0] sel_xr, sel_xi, sel_cr, sel_ci;
  logic signed [PW-1:0] diff_r, diff_i;
  logic signed [DATA_WIDTH-1:0] inc_r, inc_i;

  // Both FIFOs must have data; a lone non-empty side is never popped.
  assign pop  = (state_q == S_LOAD) && !xreal_in_empty && !ximag_in_empty;
  assign push = (state_q == S_OUT) && !yreal_out_full && !yimag_out_full;

  assign xreal_in_rd_en  = pop && !reset;
  assign ximag_in_rd_en  = pop && !reset;
  assign yreal_out_wr_en = push && !reset;
  assign yimag_out_wr_en = push && !reset;
  assign yreal_out_din   = acc_r_q;
  assign yimag_out_din   = acc_i_q;

  always_comb begin
    state_d   = state_q;
    sr_r_d    = sr_r_q;
    sr_i_d    = sr_i_q;
    pop_cnt_d = pop_cnt_q;
    tap_cnt_d = tap_cnt_q;
    pr_d      = pr_q;
    pi_d      = pi_q;
    pri_d     = pri_q;
    pir_d     = pir_q;
    acc_r_d   = acc_r_q;
    acc_i_d   = acc_i_q;

    // Tap operand mux for the multiply stage.
    sel_xr = '0;
    sel_xi = '0;
    sel_cr = '0;
    sel_ci = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (tap_cnt_q == TAP_W'(k)) begin
        sel_xr = sr_r_q[k];
        sel_xi = sr_i_q[k];
        sel_cr = $signed(COEFF_REAL[k]);
        sel_ci = $signed(COEFF_IMAG[k]);
      end
    end

    // Dequantise the previous cycle's products; truncation wraps.
    diff_r = pr_q - pi_q;
    diff_i = pri_q - pir_q;
    inc_r  = DATA_WIDTH'(diff_r >>> FRAC_BITS);
    inc_i  = DATA_WIDTH'(diff_i >>> FRAC_BITS);

    case (state_q)
      S_LOAD: begin
        if (pop) begin
          for (int k = NUM_TAPS - 1; k > 0; k--) begin
            sr_r_d[k] = sr_r_q[k-1];
            sr_i_d[k] = sr_i_q[k-1];
          end
          sr_r_d[0] = $signed(xreal_in_dout);
          sr_i_d[0] = $signed(ximag_in_dout);
          if (pop_cnt_q == LAST_POP) begin
            pop_cnt_d = '0;
            tap_cnt_d = '0;
            state_d   = S_MAC;
          end else begin
            pop_cnt_d = pop_cnt_q + 1'b1;
          end
        end
      end

      S_MAC: begin
        // Stage 1: multiply the current tap (skipped on the drain cycle).
        if (tap_cnt_q < LAST_TAP) begin
          pr_d  = PW'(sel_xr) * PW'(sel_cr);
          pi_d  = PW'(sel_xi) * PW'(sel_ci);
          pri_d = PW'(sel_cr) * PW'(sel_xi);
          pir_d = PW'(sel_ci) * PW'(sel_xr);
        end
        // Stage 2: accumulate the tap multiplied last cycle.
        if (tap_cnt_q != '0) begin
          acc_r_d = acc_r_q + inc_r;
          acc_i_d = acc_i_q + inc_i;
        end
        if (tap_cnt_q == LAST_TAP) begin
          tap_cnt_d = '0;
          state_d   = S_OUT;
        end else begin
          tap_cnt_d = tap_cnt_q + 1'b1;
        end
      end

      S_OUT: begin
        if (push) begin
          acc_r_d = '0;
          acc_i_d = '0;
          state_d = S_LOAD;
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_LOAD;
      pop_cnt_q <= '0;
      tap_cnt_q <= '0;
      pr_q      <= '0;
      pi_q      <= '0;
      pri_q     <= '0;
      pir_q     <= '0;
      acc_r_q   <= '0;
      acc_i_q   <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        sr_r_q[k] <= '0;
        sr_i_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pop_cnt_q <= pop_cnt_d;
      tap_cnt_q <= tap_cnt_d;
      pr_q      <= pr_d;
      pi_q      <= pi_d;
      pri_q     <= pri_d;
      pir_q     <= pir_d;
      acc_r_q   <= acc_r_d;
      acc_i_q   <= acc_i_d;
      sr_r_q    <= sr_r_d;
      sr_i_q    <= sr_i_d;
    end
  end

endmodule
